// File: rtl/instr_pipeline_if.sv
// Bus bundle between the memory/control side and instr_pipeline.
// The slave modport is the pipeline's view of the bus.
interface instr_pipeline_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16,
   parameter int STAGES     = 2
);
   logic [DATA_WIDTH-1:0]        MEM_DATA;
   logic                         STALL;
   logic                         CANCEL;
   logic                         BRANCH_LOAD;
   logic [ADDR_WIDTH-1:0]        BRANCH_ADDR;
   logic [ADDR_WIDTH-1:0]        PC;
   logic [STAGES*DATA_WIDTH-1:0] STAGE_INSTR;
   logic [STAGES-1:0]            STAGE_VALID;
   logic                         HALT;
   logic [15:0]                  RETIRED_COUNT;

   modport master (
      output MEM_DATA, STALL, CANCEL, BRANCH_LOAD, BRANCH_ADDR,
      input  PC, STAGE_INSTR, STAGE_VALID, HALT, RETIRED_COUNT
   );

   modport slave (
      input  MEM_DATA, STALL, CANCEL, BRANCH_LOAD, BRANCH_ADDR,
      output PC, STAGE_INSTR, STAGE_VALID, HALT, RETIRED_COUNT
   );
endinterface

// File: rtl/instr_pipeline.sv
// STAGES-deep instruction fetch/dispatch pipeline with stall, flush, branch and halt.
// Define PIPELINE_PERF_COUNTER_EN to implement RETIRED_COUNT; otherwise it reads 0.
module instr_pipeline #(
   parameter int          DATA_WIDTH  = 8,
   parameter int          ADDR_WIDTH  = 16,
   parameter int          STAGES      = 2,
   parameter int unsigned RESET_PC    = 0,
   parameter int unsigned HALT_OPCODE = 8'hFF
) (
   input logic             CLK,
   input logic             RST,
   instr_pipeline_if.slave bus
);
   localparam logic [DATA_WIDTH-1:0] HALT_OP = DATA_WIDTH'(HALT_OPCODE);
   localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);
   localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);

   logic [DATA_WIDTH-1:0]        instr_q [STAGES];
   logic [STAGES-1:0]            valid_q;
   logic [ADDR_WIDTH-1:0]        pc_q;
   logic                         halt_q;
   logic [ADDR_WIDTH-1:0]        pc_next;
   logic                         halt_hit;
   logic                         flush;
   logic                         advance;
   logic [STAGES*DATA_WIDTH-1:0] stage_flat;

   // Halting edge outranks CANCEL/STALL; it only sets HALT (and retires).
   always_comb begin
      halt_hit = !halt_q && valid_q[STAGES-1] && (instr_q[STAGES-1] == HALT_OP);
      flush    = !halt_q && !halt_hit && bus.CANCEL;
      advance  = !halt_q && !halt_hit && !bus.CANCEL && !bus.STALL;
      pc_next  = bus.BRANCH_LOAD ? bus.BRANCH_ADDR : pc_q + PC_ONE;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pc_q    <= PC_INIT;
         valid_q <= '0;
         halt_q  <= 1'b0;
         for (int unsigned i = 0; i < STAGES; i++) instr_q[i] <= '0;
      end else begin
         if (halt_hit) halt_q <= 1'b1;
         if (flush) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < STAGES; i++) instr_q[i] <= '0;
            pc_q <= pc_next;
         end else if (advance) begin
            instr_q[0] <= bus.MEM_DATA;
            for (int unsigned i = 1; i < STAGES; i++) instr_q[i] <= instr_q[i-1];
            valid_q <= {valid_q[STAGES-2:0], 1'b1};
            pc_q    <= pc_next;
         end
      end
   end

   always_comb begin
      stage_flat = '0;
      for (int unsigned i = 0; i < STAGES; i++)
         stage_flat[i*DATA_WIDTH +: DATA_WIDTH] = instr_q[i];
   end

   assign bus.PC          = pc_q;
   assign bus.STAGE_INSTR = stage_flat;
   assign bus.STAGE_VALID = valid_q;
   assign bus.HALT        = halt_q;

`ifdef PIPELINE_PERF_COUNTER_EN
   logic        retire;
   logic [15:0] retired_q;

   assign retire = valid_q[STAGES-1] && (halt_hit || flush || advance);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)         retired_q <= '0;
      else if (retire) retired_q <= retired_q + 16'd1;
   end

   assign bus.RETIRED_COUNT = retired_q;
`else
   assign bus.RETIRED_COUNT = '0;
`endif
endmodule

// File: tb/tb_instr_pipeline.sv
// Scoreboard bench for instr_pipeline: two instances (2-stage/16-bit PC, 4-stage/4-bit PC).
// Stimulus pushes expected post-edge state; a monitor pops and compares.
module tb_instr_pipeline;
   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   always #5 clk = ~clk;

   instr_pipeline_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .STAGES(2)) ia ();
   instr_pipeline_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4),  .STAGES(4)) ib ();

   instr_pipeline #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .STAGES(2),
                    .RESET_PC(0), .HALT_OPCODE(8'hFF))
      dut_a (.CLK(clk), .RST(rst_a), .bus(ia));

   instr_pipeline #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .STAGES(4),
                    .RESET_PC(0), .HALT_OPCODE(8'hFF))
      dut_b (.CLK(clk), .RST(rst_b), .bus(ib));

   typedef struct {
      int          id;
      string       name;
      logic [15:0] pc;
      logic [31:0] instr;
      logic [3:0]  valid;
      logic        halt;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   event sample_ev;

   function automatic void check(string name, string field, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got %h, expected %h", name, field, act, exp);
      end
   endfunction

   function automatic void push(int id, string name, logic [15:0] pc, logic [31:0] ins,
                                logic [3:0] v, logic h, logic [15:0] cnt);
      exp_t e;
      e.id = id; e.name = name; e.pc = pc; e.instr = ins; e.valid = v; e.halt = h;
`ifdef PIPELINE_PERF_COUNTER_EN
      e.cnt = cnt;
`else
      e.cnt = 16'h0000;
`endif
      sb.push_back(e);
   endfunction

   // Monitor: compares every queued expectation after the next edge (or on demand).
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or sample_ev);
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.id == 0) begin
               check(e.name, "pc",    32'(ia.PC),            32'(e.pc));
               check(e.name, "instr", 32'(ia.STAGE_INSTR),   e.instr);
               check(e.name, "valid", 32'(ia.STAGE_VALID),   32'(e.valid));
               check(e.name, "halt",  32'(ia.HALT),          32'(e.halt));
               check(e.name, "cnt",   32'(ia.RETIRED_COUNT), 32'(e.cnt));
            end else begin
               check(e.name, "pc",    32'(ib.PC),            32'(e.pc));
               check(e.name, "instr", 32'(ib.STAGE_INSTR),   e.instr);
               check(e.name, "valid", 32'(ib.STAGE_VALID),   32'(e.valid));
               check(e.name, "halt",  32'(ib.HALT),          32'(e.halt));
               check(e.name, "cnt",   32'(ib.RETIRED_COUNT), 32'(e.cnt));
            end
         end
      end
   end

   task automatic drive(int id, logic [7:0] mem, logic st, logic ca, logic bl, logic [15:0] ba);
      if (id == 0) begin
         ia.MEM_DATA = mem; ia.STALL = st; ia.CANCEL = ca; ia.BRANCH_LOAD = bl; ia.BRANCH_ADDR = ba;
      end else begin
         ib.MEM_DATA = mem; ib.STALL = st; ib.CANCEL = ca; ib.BRANCH_LOAD = bl; ib.BRANCH_ADDR = ba[3:0];
      end
   endtask

   task automatic step(int id, string name, logic [7:0] mem, logic st, logic ca, logic bl,
                       logic [15:0] ba, logic [15:0] pc, logic [31:0] ins, logic [3:0] v,
                       logic h, logic [15:0] cnt);
      @(negedge clk);
      drive(id, mem, st, ca, bl, ba);
      push(id, name, pc, ins, v, h, cnt);
   endtask

   // Asserts reset mid-cycle (checked before any edge), then releases it with STALL held.
   task automatic do_reset(int id, string name);
      @(negedge clk);
      drive(id, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000);
      if (id == 0) rst_a = 1'b1; else rst_b = 1'b1;
      push(id, {name, "_async"}, 16'h0, 32'h0, 4'h0, 1'b0, 16'h0);
      -> sample_ev;
      @(negedge clk);
      if (id == 0) rst_a = 1'b0; else rst_b = 1'b0;
      drive(id, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000);
      push(id, {name, "_rel"}, 16'h0, 32'h0, 4'h0, 1'b0, 16'h0);
   endtask

   initial begin
      drive(0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000);
      drive(1, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000);
      repeat (2) @(posedge clk);

      // ---- instance A: STAGES=2, 16-bit PC ----
      do_reset(0, "a_rst");
      //        name         mem    st    ca    bl    ba        pc        instr         v     h     cnt
      step(0, "fill1",     8'h11, 1'b0, 1'b0, 1'b0, 16'h0,    16'h0001, 32'h0011, 4'b0001, 1'b0, 16'd0);
      step(0, "fill2",     8'h22, 1'b0, 1'b0, 1'b0, 16'h0,    16'h0002, 32'h1122, 4'b0011, 1'b0, 16'd0);
      step(0, "adv3",      8'h33, 1'b0, 1'b0, 1'b0, 16'h0,    16'h0003, 32'h2233, 4'b0011, 1'b0, 16'd1);
      step(0, "adv4",      8'h44, 1'b0, 1'b0, 1'b0, 16'h0,    16'h0004, 32'h3344, 4'b0011, 1'b0, 16'd2);
      step(0, "adv5",      8'h55, 1'b0, 1'b0, 1'b0, 16'h0,    16'h0005, 32'h4455, 4'b0011, 1'b0, 16'd3);
      step(0, "stall1",    8'h66, 1'b1, 1'b0, 1'b0, 16'h0,    16'h0005, 32'h4455, 4'b0011, 1'b0, 16'd3);
      step(0, "stall2_bl", 8'h66, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h0005, 32'h4455, 4'b0011, 1'b0, 16'd3);
      step(0, "stall3",    8'h66, 1'b1, 1'b0, 1'b0, 16'h0,    16'h0005, 32'h4455, 4'b0011, 1'b0, 16'd3);
      step(0, "resume",    8'h66, 1'b0, 1'b0, 1'b0, 16'h0,    16'h0006, 32'h5566, 4'b0011, 1'b0, 16'd4);
      step(0, "adv7",      8'h77, 1'b0, 1'b0, 1'b0, 16'h0,    16'h0007, 32'h6677, 4'b0011, 1'b0, 16'd5);
      step(0, "dslot_br",  8'h88, 1'b0, 1'b0, 1'b1, 16'h0040, 16'h0040, 32'h7788, 4'b0011, 1'b0, 16'd6);
      step(0, "at_40",     8'h99, 1'b0, 1'b0, 1'b0, 16'h0,    16'h0041, 32'h8899, 4'b0011, 1'b0, 16'd7);
      step(0, "cancel_br", 8'hAA, 1'b1, 1'b1, 1'b1, 16'h0100, 16'h0100, 32'h0000, 4'b0000, 1'b0, 16'd8);
      step(0, "at_100",    8'hBB, 1'b0, 1'b0, 1'b0, 16'h0,    16'h0101, 32'h00BB, 4'b0001, 1'b0, 16'd8);
      step(0, "cancel_nb", 8'hCC, 1'b0, 1'b1, 1'b0, 16'h0,    16'h0102, 32'h0000, 4'b0000, 1'b0, 16'd8);
      step(0, "adv_dd",    8'hDD, 1'b0, 1'b0, 1'b0, 16'h0,    16'h0103, 32'h00DD, 4'b0001, 1'b0, 16'd8);
      step(0, "halt_s0",   8'hFF, 1'b0, 1'b0, 1'b0, 16'h0,    16'h0104, 32'hDDFF, 4'b0011, 1'b0, 16'd8);
      step(0, "halt_fin",  8'h01, 1'b0, 1'b0, 1'b0, 16'h0,    16'h0105, 32'hFF01, 4'b0011, 1'b0, 16'd9);
      step(0, "halt_edge", 8'h02, 1'b0, 1'b1, 1'b1, 16'h0,    16'h0105, 32'hFF01, 4'b0011, 1'b1, 16'd10);
      step(0, "frozen1",   8'h03, 1'b0, 1'b1, 1'b0, 16'h0,    16'h0105, 32'hFF01, 4'b0011, 1'b1, 16'd10);
      step(0, "frozen2",   8'h04, 1'b0, 1'b0, 1'b0, 16'h0,    16'h0105, 32'hFF01, 4'b0011, 1'b1, 16'd10);
      do_reset(0, "a_midrst");
      step(0, "post_rst",  8'h5A, 1'b0, 1'b0, 1'b0, 16'h0,    16'h0001, 32'h005A, 4'b0001, 1'b0, 16'd0);
`ifdef PIPELINE_PERF_COUNTER_EN
      for (int i = 0; i < 65535; i++) begin
         @(negedge clk);
         drive(0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000);
      end
      step(0, "cnt_max",   8'h00, 1'b0, 1'b0, 1'b0, 16'h0,    16'h0001, 32'h0000, 4'b0011, 1'b0, 16'hFFFF);
      step(0, "cnt_wrap",  8'h00, 1'b0, 1'b0, 1'b0, 16'h0,    16'h0002, 32'h0000, 4'b0011, 1'b0, 16'h0000);
`endif

      // ---- instance B: STAGES=4, 4-bit PC ----
      do_reset(1, "b_rst");
      step(1, "b_f1",      8'h10, 1'b0, 1'b0, 1'b0, 16'h0,    16'h1, 32'h00000010, 4'b0001, 1'b0, 16'd0);
      step(1, "b_f2",      8'h20, 1'b0, 1'b0, 1'b0, 16'h0,    16'h2, 32'h00001020, 4'b0011, 1'b0, 16'd0);
      step(1, "b_f3",      8'h30, 1'b0, 1'b0, 1'b0, 16'h0,    16'h3, 32'h00102030, 4'b0111, 1'b0, 16'd0);
      step(1, "b_fetchff", 8'hFF, 1'b0, 1'b0, 1'b0, 16'h0,    16'h4, 32'h102030FF, 4'b1111, 1'b0, 16'd0);
      step(1, "b_e2",      8'h40, 1'b0, 1'b0, 1'b0, 16'h0,    16'h5, 32'h2030FF40, 4'b1111, 1'b0, 16'd1);
      step(1, "b_e3",      8'h50, 1'b0, 1'b0, 1'b0, 16'h0,    16'h6, 32'h30FF4050, 4'b1111, 1'b0, 16'd2);
      step(1, "b_e4",      8'h60, 1'b0, 1'b0, 1'b0, 16'h0,    16'h7, 32'hFF405060, 4'b1111, 1'b0, 16'd3);
      step(1, "b_halt",    8'h70, 1'b0, 1'b1, 1'b0, 16'h0,    16'h7, 32'hFF405060, 4'b1111, 1'b1, 16'd4);
      step(1, "b_frozen",  8'h80, 1'b0, 1'b1, 1'b1, 16'h2,    16'h7, 32'hFF405060, 4'b1111, 1'b1, 16'd4);

      do_reset(1, "c_rst");
      step(1, "c_f1",      8'h10, 1'b0, 1'b0, 1'b0, 16'h0,    16'h1, 32'h00000010, 4'b0001, 1'b0, 16'd0);
      step(1, "c_f2",      8'h20, 1'b0, 1'b0, 1'b0, 16'h0,    16'h2, 32'h00001020, 4'b0011, 1'b0, 16'd0);
      step(1, "c_f3",      8'h30, 1'b0, 1'b0, 1'b0, 16'h0,    16'h3, 32'h00102030, 4'b0111, 1'b0, 16'd0);
      step(1, "c_fetchff", 8'hFF, 1'b0, 1'b0, 1'b0, 16'h0,    16'h4, 32'h102030FF, 4'b1111, 1'b0, 16'd0);
      step(1, "c_cancel",  8'h40, 1'b0, 1'b1, 1'b0, 16'h0,    16'h5, 32'h00000000, 4'b0000, 1'b0, 16'd1);
      step(1, "c_a6",      8'h00, 1'b0, 1'b0, 1'b0, 16'h0,    16'h6, 32'h00000000, 4'b0001, 1'b0, 16'd1);
      step(1, "c_a7",      8'h00, 1'b0, 1'b0, 1'b0, 16'h0,    16'h7, 32'h00000000, 4'b0011, 1'b0, 16'd1);
      step(1, "c_a8",      8'h00, 1'b0, 1'b0, 1'b0, 16'h0,    16'h8, 32'h00000000, 4'b0111, 1'b0, 16'd1);
      step(1, "c_a9",      8'h00, 1'b0, 1'b0, 1'b0, 16'h0,    16'h9, 32'h00000000, 4'b1111, 1'b0, 16'd1);
      step(1, "c_no_halt", 8'h00, 1'b0, 1'b0, 1'b0, 16'h0,    16'hA, 32'h00000000, 4'b1111, 1'b0, 16'd2);
      step(1, "c_br_f",    8'h00, 1'b0, 1'b0, 1'b1, 16'hF,    16'hF, 32'h00000000, 4'b1111, 1'b0, 16'd3);
      step(1, "c_wrap",    8'h00, 1'b0, 1'b0, 1'b0, 16'h0,    16'h0, 32'h00000000, 4'b1111, 1'b0, 16'd4);

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
